cnt5_rr_ctrl: RTL and testbench



---
 rtl/cnt5_rr_ctrl.sv | 121 ++++++++++++
 tb/tb_cnt5_rr_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cnt5_rr_ctrl.sv
// cnt5_rr_ctrl: round-robin arbiter sharing one mod-5 up/down counter among N
// requesters. One grant per cycle, registered one-hot gnt, and one idle WRAP
// cycle inserted after any operation that wraps the counter.
//
// Handshake: req is a level request. A requester owns the counter operation in
// the cycle its gnt bit is high; gnt is registered and never combinationally
// follows req. A requester wanting exactly one operation drops req in the cycle
// it sees its gnt bit.
module cnt5_rr_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic [N-1:0] req,
  input  logic [N-1:0] dir,
  output logic [N-1:0] gnt,
  output logic [2:0]   cnt,
  output logic         wrap,
  output logic [1:0]   state_dbg
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WRAP  = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic          wrap_flag;

  logic          found;
  logic [PW-1:0] win;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic [2:0]    cnt_next;
  logic          wrap_next;
  logic [PW-1:0] ptr_next;

  assign state_dbg = state;

  // Round-robin search: first requesting index at or above ptr, modulo N.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Mod-5 counter step for the winner's direction, plus its wrap indication.
  always_comb begin
    cnt_next  = cnt;
    wrap_next = 1'b0;
    if (dir[win]) begin
      if (cnt == 3'd4) begin
        cnt_next  = 3'd0;
        wrap_next = 1'b1;
      end else begin
        cnt_next = cnt + 3'd1;
      end
    end else begin
      if (cnt == 3'd0) begin
        cnt_next  = 3'd4;
        wrap_next = 1'b1;
      end else begin
        cnt_next = cnt - 3'd1;
      end
    end
    ptr_next = (win == PW'(N-1)) ? '0 : win + PW'(1);
  end

  // Controller FSM with registered outputs; clr beats the wrap bubble, which
  // beats new requests (req is not even looked at during the bubble edge).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      gnt       <= '0;
      wrap      <= 1'b0;
      wrap_flag <= 1'b0;
      ptr       <= '0;
    end else if (clr) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      gnt       <= '0;
      wrap      <= 1'b0;
      wrap_flag <= 1'b0;
      ptr       <= '0;
    end else if (state == S_GRANT && wrap_flag) begin
      state     <= S_WRAP;
      gnt       <= '0;
      wrap      <= 1'b1;
      wrap_flag <= 1'b0;
    end else if (found) begin
      state     <= S_GRANT;
      cnt       <= cnt_next;
      gnt       <= {{(N-1){1'b0}}, 1'b1} << win;
      wrap      <= 1'b0;
      wrap_flag <= wrap_next;
      ptr       <= ptr_next;
    end else begin
      state     <= S_IDLE;
      gnt       <= '0;
      wrap      <= 1'b0;
      wrap_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnt5_rr_ctrl.sv
// Directed bench for cnt5_rr_ctrl (N=4) with hand-computed expectations.
module tb_cnt5_rr_ctrl;

  localparam int N = 4;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_WRAP  = 2'd2;

  logic         clk;
  logic         reset_n;
  logic         clr;
  logic [N-1:0] req;
  logic [N-1:0] dir;
  logic [N-1:0] gnt;
  logic [2:0]   cnt;
  logic         wrap;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad   = 0;

  cnt5_rr_ctrl #(.N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .req       (req),
    .dir       (dir),
    .gnt       (gnt),
    .cnt       (cnt),
    .wrap      (wrap),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [N-1:0] g, input logic [2:0] c,
                           input logic w, input logic [1:0] s);
    check({tag, ".gnt"},   32'(gnt),       32'(g));
    check({tag, ".cnt"},   32'(cnt),       32'(c));
    check({tag, ".wrap"},  32'(wrap),      32'(w));
    check({tag, ".state"}, 32'(state_dbg), 32'(s));
  endtask

  // Advance one rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] d, input logic c);
    req = r;
    dir = d;
    clr = c;
  endtask

  // Asynchronous reset pulse taken mid-cycle, away from any edge.
  task automatic do_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    check_all({tag, ".rst"}, 4'b0000, 3'd0, 1'b0, ST_IDLE);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0);
    #3;
    check_all("por", 4'b0000, 3'd0, 1'b0, ST_IDLE);
    tick();
    reset_n = 1'b1;

    // Build cnt=3 with gnt=0010, then reset in the middle of the cycle.
    drive(4'b0010, 4'b1111, 1'b0);
    tick(); check_all("r1", 4'b0010, 3'd1, 1'b0, ST_GRANT);
    tick(); check_all("r2", 4'b0010, 3'd2, 1'b0, ST_GRANT);
    tick(); check_all("r3", 4'b0010, 3'd3, 1'b0, ST_GRANT);
    drive(4'b0000, 4'b0000, 1'b0);
    do_reset("midgrant");
    tick(); check_all("post_rst_idle", 4'b0000, 3'd0, 1'b0, ST_IDLE);

    // Round robin from reset, all incrementing, through a wrap.
    drive(4'b1111, 4'b1111, 1'b0);
    tick(); check_all("rr1", 4'b0001, 3'd1, 1'b0, ST_GRANT);
    tick(); check_all("rr2", 4'b0010, 3'd2, 1'b0, ST_GRANT);
    tick(); check_all("rr3", 4'b0100, 3'd3, 1'b0, ST_GRANT);
    tick(); check_all("rr4", 4'b1000, 3'd4, 1'b0, ST_GRANT);
    tick(); check_all("rr5", 4'b0001, 3'd0, 1'b0, ST_GRANT);
    tick(); check_all("rr_wrap", 4'b0000, 3'd0, 1'b1, ST_WRAP);
    tick(); check_all("rr6", 4'b0010, 3'd1, 1'b0, ST_GRANT);
    drive(4'b0000, 4'b1111, 1'b0);
    tick(); check_all("rr_idle", 4'b0000, 3'd1, 1'b0, ST_IDLE);

    // Fairness with gaps: pointer now at 2, only requesters 0 and 1 asking.
    drive(4'b0011, 4'b1111, 1'b0);
    tick(); check_all("fair1", 4'b0001, 3'd2, 1'b0, ST_GRANT);
    tick(); check_all("fair2", 4'b0010, 3'd3, 1'b0, ST_GRANT);
    tick(); check_all("fair3", 4'b0001, 3'd4, 1'b0, ST_GRANT);
    drive(4'b0000, 4'b1111, 1'b0);
    tick(); check_all("fair_idle", 4'b0000, 3'd4, 1'b0, ST_IDLE);

    // Single requester incrementing from reset for 7 cycles.
    do_reset("inc");
    drive(4'b0001, 4'b0001, 1'b0);
    tick(); check_all("inc1", 4'b0001, 3'd1, 1'b0, ST_GRANT);
    tick(); check_all("inc2", 4'b0001, 3'd2, 1'b0, ST_GRANT);
    tick(); check_all("inc3", 4'b0001, 3'd3, 1'b0, ST_GRANT);
    tick(); check_all("inc4", 4'b0001, 3'd4, 1'b0, ST_GRANT);
    tick(); check_all("inc5", 4'b0001, 3'd0, 1'b0, ST_GRANT);
    tick(); check_all("inc_wrap", 4'b0000, 3'd0, 1'b1, ST_WRAP);
    tick(); check_all("inc6", 4'b0001, 3'd1, 1'b0, ST_GRANT);
    drive(4'b0000, 4'b0000, 1'b0);
    tick(); check_all("inc_idle", 4'b0000, 3'd1, 1'b0, ST_IDLE);

    // Decrement wrap from 0 by a single one-shot request.
    do_reset("dec");
    drive(4'b0010, 4'b0000, 1'b0);
    tick(); check_all("dec1", 4'b0010, 3'd4, 1'b0, ST_GRANT);
    drive(4'b0000, 4'b0000, 1'b0);
    tick(); check_all("dec_wrap", 4'b0000, 3'd4, 1'b1, ST_WRAP);
    tick(); check_all("dec_idle", 4'b0000, 3'd4, 1'b0, ST_IDLE);

    // Clear precedence over a simultaneous request.
    do_reset("clr");
    drive(4'b0100, 4'b1111, 1'b0);
    tick(); check_all("clr_a", 4'b0100, 3'd1, 1'b0, ST_GRANT);
    tick(); check_all("clr_b", 4'b0100, 3'd2, 1'b0, ST_GRANT);
    drive(4'b0100, 4'b1111, 1'b1);
    tick(); check_all("clr_win", 4'b0000, 3'd0, 1'b0, ST_IDLE);
    drive(4'b0100, 4'b1111, 1'b0);
    tick(); check_all("clr_after", 4'b0100, 3'd1, 1'b0, ST_GRANT);
    drive(4'b0000, 4'b1111, 1'b0);
    tick(); check_all("clr_idle", 4'b0000, 3'd1, 1'b0, ST_IDLE);

    // Clear arriving while in the WRAP cycle.
    do_reset("clrwrap");
    drive(4'b0001, 4'b0000, 1'b0);
    tick(); check_all("cw1", 4'b0001, 3'd4, 1'b0, ST_GRANT);
    drive(4'b0000, 4'b0000, 1'b0);
    tick(); check_all("cw_wrap", 4'b0000, 3'd4, 1'b1, ST_WRAP);
    drive(4'b0000, 4'b0000, 1'b1);
    tick(); check_all("cw_clr", 4'b0000, 3'd0, 1'b0, ST_IDLE);
    drive(4'b0000, 4'b0000, 1'b0);

    // Back-to-back wraps: dec from 0, then inc from 4, each with its own bubble.
    do_reset("b2b");
    drive(4'b0001, 4'b0000, 1'b0);
    tick(); check_all("b2b1", 4'b0001, 3'd4, 1'b0, ST_GRANT);
    drive(4'b0001, 4'b0001, 1'b0);
    tick(); check_all("b2b_w1", 4'b0000, 3'd4, 1'b1, ST_WRAP);
    tick(); check_all("b2b2", 4'b0001, 3'd0, 1'b0, ST_GRANT);
    drive(4'b0000, 4'b0000, 1'b0);
    tick(); check_all("b2b_w2", 4'b0000, 3'd0, 1'b1, ST_WRAP);

    // Reset in the middle of a WRAP cycle, then requester-0 priority restored.
    drive(4'b0001, 4'b0000, 1'b0);
    tick(); check_all("mw1", 4'b0001, 3'd4, 1'b0, ST_GRANT);
    drive(4'b0000, 4'b0000, 1'b0);
    tick(); check_all("mw_wrap", 4'b0000, 3'd4, 1'b1, ST_WRAP);
    do_reset("midwrap");
    drive(4'b1010, 4'b1111, 1'b0);
    tick(); check_all("mw_after", 4'b0010, 3'd1, 1'b0, ST_GRANT);
    drive(4'b0000, 4'b0000, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
